load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_BYTES, default 4096, data-memory size in bytes; byte addresses >= MEM_BYTES are out of range.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  core presents a load/store request.
REQ-006 req_ready  out  1  high only in IDLE; a request is accepted when req_valid&req_ready.
REQ-007 req_is_store  in  1  1=store, 0=load.
REQ-008 req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
REQ-009 req_base, req_offset  in  32 each  effective address = req_base + req_offset, modulo 2^32.
REQ-010 req_wdata  in  32  store data; req_rd  in  5  load destination register.
REQ-011 resp_valid  out  1  completion or exception; resp_ready  in  1  core accepts it.
REQ-012 resp_data  out  32  formatted load data; resp_rd  out  5; resp_we  out  1  high for a successful load only.
REQ-013 exc  out  1  response is an exception; exc_cause  out  2; exc_addr  out  32  faulting effective address.
REQ-014 mem_read_en, mem_write_en  out  1 each; mem_address, mem_write_data  out  32 each; mem_funct3  out  3.
REQ-015 mem_read_data  in  32  formatted read data from the data memory, valid in the cycle after mem_read_en is high.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, RESP and EXC.
REQ-017 Accept in IDLE: register the effective address, funct3, wdata, rd and is_store, then check the request.
  - Any check fails: go to EXC.
  - Otherwise: go to ISSUE.
REQ-018 Checks, highest priority first:
  - Illegal funct3: loads 011/110/111; stores >= 011. Cause 11.
  - Misaligned: half-word with addr[0] set, or word with addr[1:0] nonzero. Cause 01 for a load, 10 for a store.
  - Out of range: addr >= MEM_BYTES. Cause 00.
REQ-019 ISSUE (exactly one cycle): drive mem_address, mem_funct3 and mem_write_data from the registered request.
  - Load: mem_read_en=1, then go to WAIT.
  - Store: mem_write_en=1, then go to RESP.
REQ-020 WAIT (one cycle): capture mem_read_data into resp_data, then go to RESP.
REQ-021 RESP: hold resp_valid=1 and all response fields stable until resp_ready; then go to IDLE.
  - Load: resp_we=1.
  - Store: resp_we=0 and resp_data=0.
REQ-022 EXC: hold resp_valid=1, exc=1, exc_cause, exc_addr and resp_we=0 until resp_ready; then go to IDLE.
REQ-023 Memory enables SHALL be high only in ISSUE; a faulting request never reaches memory.
REQ-024 Latency from the accept edge T:
  - Load: resp_valid first high in cycle T+3.
  - Store: resp_valid first high in cycle T+2.
  - Exception: resp_valid first high in cycle T+1.
REQ-025 A load to rd=0 SHALL still access memory and respond with resp_rd=0 and resp_we=1.
REQ-026 Effective-address wrap past 2^32-1 SHALL be computed modulo 2^32 and then checked against MEM_BYTES.
REQ-027 req_valid while req_ready is low SHALL be ignored; the core holds the request until it is accepted.

Reset
REQ-028 On rst the FSM SHALL go to IDLE, regardless of state.
REQ-029 While in reset, every output SHALL be 0 except req_ready, which is 1 in the cycle after reset.
REQ-030 Reset in mid-operation SHALL discard the pending request with no response; a write already issued in ISSUE is not undone.

Configuration
REQ-031 Macro LSU_FAST_RESP_EN.
  - Defined: load resp_valid is asserted in WAIT with resp_data = mem_read_data directly; load latency is T+2.
  - Defined, resp_ready low in WAIT: capture the data and continue in RESP as normal.
  - Undefined: behaviour as REQ-020 and REQ-024.

Verification
REQ-032 Store then load: SW 0xDEADBEEF at 0x10, then LW 0x10 with rd=5 -> resp_data=0xDEADBEEF, resp_rd=5, resp_we=1, resp_valid at T+3.
REQ-033 Sign handling: LB 0x11 then LBU 0x11 after the store above -> 0xFFFFFFBE, then 0x000000BE.
REQ-034 Misaligned access: SH at base 0x20, offset 1 -> exc=1, cause 10, exc_addr=0x21, no mem_write_en pulse, response at T+1.
REQ-035 Out-of-range and illegal funct3:
  - LW at 0x1000 with MEM_BYTES=4096 -> cause 00.
  - Load with funct3=011 -> cause 11.
REQ-036 Backpressure and reset: hold resp_ready low 5 cycles, then pulse it -> outputs stable throughout, one completion; assert rst in WAIT -> no response, req_ready=1 the next cycle.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response channel of the load/store unit.
// master = core, slave = LSU.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_base;
   logic [31:0] req_offset;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_we;
   logic        exc;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;

   modport master (
      output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
      output resp_ready,
      input  req_ready,
      input  resp_valid, resp_data, resp_rd, resp_we, exc, exc_cause, exc_addr
   );

   modport slave (
      input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
      input  resp_ready,
      output req_ready,
      output resp_valid, resp_data, resp_rd, resp_we, exc, exc_cause, exc_addr
   );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks, issues one memory access, holds the response until resp_ready.
// Latency load T+3 / store T+2 / fault T+1; LSU_FAST_RESP_EN answers loads in WAIT (T+2).
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.slave   core,
   output logic               mem_read_en,
   output logic               mem_write_en,
   output logic [31:0]        mem_address,
   output logic [31:0]        mem_write_data,
   output logic [2:0]         mem_funct3,
   input  logic [31:0]        mem_read_data
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, EXC} state_t;

   typedef struct packed {
      logic        is_store;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   state_t      state_q, state_d;
   req_t        req_q, req_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic [4:0]  resp_rd_q, resp_rd_d;
   logic        resp_we_q, resp_we_d;
   logic        exc_q, exc_d;
   logic [1:0]  exc_cause_q, exc_cause_d;
   logic [31:0] exc_addr_q, exc_addr_d;
   logic        mem_read_en_q, mem_read_en_d;
   logic        mem_write_en_q, mem_write_en_d;

   logic [31:0] eff_addr;
   logic        illegal, misaligned, out_of_range, fault;
   logic [1:0]  fault_cause;
   logic        issuing;

   always_comb begin
      eff_addr     = core.req_base + core.req_offset;
      if (core.req_is_store)
         illegal = (core.req_funct3 >= 3'b011);
      else
         illegal = (core.req_funct3 == 3'b011) || (core.req_funct3 == 3'b110) ||
                   (core.req_funct3 == 3'b111);
      misaligned   = ((core.req_funct3[1:0] == 2'b01) && eff_addr[0]) ||
                     ((core.req_funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
      out_of_range = (eff_addr >= MEM_BYTES);
      fault        = illegal || misaligned || out_of_range;
      if (illegal)
         fault_cause = 2'b11;
      else if (misaligned)
         fault_cause = core.req_is_store ? 2'b10 : 2'b01;
      else
         fault_cause = 2'b00;
   end

   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      req_ready_d    = req_ready_q;
      resp_valid_d   = resp_valid_q;
      resp_data_d    = resp_data_q;
      resp_rd_d      = resp_rd_q;
      resp_we_d      = resp_we_q;
      exc_d          = exc_q;
      exc_cause_d    = exc_cause_q;
      exc_addr_d     = exc_addr_q;
      mem_read_en_d  = 1'b0;
      mem_write_en_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (core.req_valid && req_ready_q) begin
               req_d       = '{is_store: core.req_is_store, funct3: core.req_funct3,
                               rd: core.req_rd, addr: eff_addr, wdata: core.req_wdata};
               req_ready_d = 1'b0;
               if (fault) begin
                  state_d      = EXC;
                  resp_valid_d = 1'b1;
                  resp_data_d  = '0;
                  resp_rd_d    = core.req_rd;
                  resp_we_d    = 1'b0;
                  exc_d        = 1'b1;
                  exc_cause_d  = fault_cause;
                  exc_addr_d   = eff_addr;
               end else begin
                  state_d        = ISSUE;
                  mem_read_en_d  = !core.req_is_store;
                  mem_write_en_d = core.req_is_store;
               end
            end
         end
         ISSUE: begin
            if (req_q.is_store) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_data_d  = '0;
               resp_rd_d    = req_q.rd;
               resp_we_d    = 1'b0;
            end else begin
               state_d = WAIT;
`ifdef LSU_FAST_RESP_EN
               resp_valid_d = 1'b1;
               resp_rd_d    = req_q.rd;
               resp_we_d    = 1'b1;
`endif
            end
         end
         WAIT: begin
            resp_data_d = mem_read_data;
`ifdef LSU_FAST_RESP_EN
            // Response already visible; if taken now, skip RESP entirely.
            if (core.resp_ready) begin
               state_d      = IDLE;
               req_ready_d  = 1'b1;
               resp_valid_d = 1'b0;
               resp_data_d  = '0;
               resp_rd_d    = '0;
               resp_we_d    = 1'b0;
            end else begin
               state_d = RESP;
            end
`else
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rd_d    = req_q.rd;
            resp_we_d    = 1'b1;
`endif
         end
         RESP, EXC: begin
            if (core.resp_ready) begin
               state_d      = IDLE;
               req_ready_d  = 1'b1;
               resp_valid_d = 1'b0;
               resp_data_d  = '0;
               resp_rd_d    = '0;
               resp_we_d    = 1'b0;
               exc_d        = 1'b0;
               exc_cause_d  = '0;
               exc_addr_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         req_q          <= '0;
         req_ready_q    <= 1'b1;
         resp_valid_q   <= 1'b0;
         resp_data_q    <= '0;
         resp_rd_q      <= '0;
         resp_we_q      <= 1'b0;
         exc_q          <= 1'b0;
         exc_cause_q    <= '0;
         exc_addr_q     <= '0;
         mem_read_en_q  <= 1'b0;
         mem_write_en_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_data_q    <= resp_data_d;
         resp_rd_q      <= resp_rd_d;
         resp_we_q      <= resp_we_d;
         exc_q          <= exc_d;
         exc_cause_q    <= exc_cause_d;
         exc_addr_q     <= exc_addr_d;
         mem_read_en_q  <= mem_read_en_d;
         mem_write_en_q <= mem_write_en_d;
      end
   end

   // Enables are only ever high in ISSUE, so they double as the ISSUE decode.
   assign issuing        = mem_read_en_q || mem_write_en_q;
   assign mem_read_en    = mem_read_en_q;
   assign mem_write_en   = mem_write_en_q;
   assign mem_address    = issuing ? req_q.addr   : '0;
   assign mem_write_data = issuing ? req_q.wdata  : '0;
   assign mem_funct3     = issuing ? req_q.funct3 : '0;

   assign core.req_ready  = req_ready_q;
   assign core.resp_valid = resp_valid_q;
`ifdef LSU_FAST_RESP_EN
   assign core.resp_data  = (state_q == WAIT) ? mem_read_data : resp_data_q;
`else
   assign core.resp_data  = resp_data_q;
`endif
   assign core.resp_rd    = resp_rd_q;
   assign core.resp_we    = resp_we_q;
   assign core.exc        = exc_q;
   assign core.exc_cause  = exc_cause_q;
   assign core.exc_addr   = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model, vector table, scoreboard queue,
// plus backpressure and mid-operation reset sequences.
module tb_load_store_unit;

   localparam int LOAD_LAT =
`ifdef LSU_FAST_RESP_EN
      2;
`else
      3;
`endif

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] base;
      logic [31:0] off;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        exc;
      logic [1:0]  cause;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      logic        exc;
      logic [1:0]  cause;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      int          lat;
      int          acc;
      int          ops0;
      int          ops;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_en, mem_write_en;
   logic [31:0] mem_address, mem_write_data;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_read_data = '0;
   logic [7:0]  mem [0:4095] = '{default: 8'h00};

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mem_ops = 0;
   int hs_cnt = 0;
   int first_cyc = 0;
   bit prev_valid = 1'b0;
   exp_t exp_q[$];
   vec_t vecs[24];

   load_store_unit_if bus ();

   load_store_unit #(.MEM_BYTES(4096)) dut (
      .clk            (clk),
      .rst            (rst),
      .core           (bus),
      .mem_read_en    (mem_read_en),
      .mem_write_en   (mem_write_en),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_funct3     (mem_funct3),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      b = mem[a[11:0]];
      h = {mem[12'(a[11:0] + 12'd1)], mem[a[11:0]]};
      w = {mem[12'(a[11:0] + 12'd3)], mem[12'(a[11:0] + 12'd2)], h};
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_read_en || mem_write_en) mem_ops <= mem_ops + 1;
      if (mem_read_en) mem_read_data <= mem_rd(mem_address, mem_funct3);
      if (mem_write_en) begin
         mem[mem_address[11:0]] <= mem_write_data[7:0];
         if (mem_funct3[1:0] != 2'b00)
            mem[12'(mem_address[11:0] + 12'd1)] <= mem_write_data[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            mem[12'(mem_address[11:0] + 12'd2)] <= mem_write_data[23:16];
            mem[12'(mem_address[11:0] + 12'd3)] <= mem_write_data[31:24];
         end
      end
   end

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [79:0] outv();
      return {6'b0, bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_we,
              bus.exc, bus.exc_cause, bus.exc_addr};
   endfunction

   function automatic logic [79:0] memv();
      return 80'({mem_read_en, mem_write_en, mem_address, mem_write_data, mem_funct3});
   endfunction

   function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] base,
                               input logic [31:0] off, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic exc, input logic [1:0] cause,
                               input logic [31:0] data);
      vec_t v;
      v.st = st; v.f3 = f3; v.base = base; v.off = off; v.wdata = wdata;
      v.rd = rd; v.exc = exc; v.cause = cause; v.data = data;
      return v;
   endfunction

   // Scoreboard: pop and compare on each completed response handshake.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.resp_valid && !prev_valid) first_cyc = cyc;
         prev_valid = bus.resp_valid;
         if (bus.resp_valid && bus.resp_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp actual=response required=none");
            end else begin
               e = exp_q.pop_front();
               chk("exc", 80'(bus.exc), 80'(e.exc));
               if (e.exc) begin
                  chk("exc_cause", 80'(bus.exc_cause), 80'(e.cause));
                  chk("exc_addr", 80'(bus.exc_addr), 80'(e.addr));
                  chk("exc_we", 80'(bus.resp_we), 80'(0));
               end else begin
                  chk("resp_data", 80'(bus.resp_data), 80'(e.data));
                  chk("resp_we", 80'(bus.resp_we), 80'(e.we));
                  if (e.we) chk("resp_rd", 80'(bus.resp_rd), 80'(e.rd));
               end
               chk("latency", 80'(first_cyc - e.acc + 1), 80'(e.lat));
               chk("mem_ops", 80'(mem_ops - e.ops0), 80'(e.ops));
            end
         end
      end
   end

   task automatic send(input vec_t v, input bit track);
      exp_t e;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_is_store = v.st;
      bus.req_funct3   = v.f3;
      bus.req_base     = v.base;
      bus.req_offset   = v.off;
      bus.req_wdata    = v.wdata;
      bus.req_rd       = v.rd;
      for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
      if (!bus.req_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout actual=req_ready_low required=accept");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.exc   = v.exc;
      e.cause = v.cause;
      e.addr  = v.base + v.off;
      e.data  = v.data;
      e.rd    = v.rd;
      e.we    = !v.exc && !v.st;
      e.lat   = v.exc ? 1 : (v.st ? 2 : LOAD_LAT);
      e.acc   = cyc;
      e.ops0  = mem_ops;
      e.ops   = v.exc ? 0 : 1;
      if (track) exp_q.push_back(e);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL resp_timeout actual=pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int hs0;
      vecs[0]  = mk(1, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 5'd0, 0, 2'b00, 32'h0);
      vecs[1]  = mk(0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd5, 0, 2'b00, 32'hDEADBEEF);
      vecs[2]  = mk(0, 3'b000, 32'h11, 32'h0, 32'h0, 5'd6, 0, 2'b00, 32'hFFFFFFBE);
      vecs[3]  = mk(0, 3'b100, 32'h11, 32'h0, 32'h0, 5'd6, 0, 2'b00, 32'h000000BE);
      vecs[4]  = mk(0, 3'b001, 32'h12, 32'h0, 32'h0, 5'd7, 0, 2'b00, 32'hFFFFDEAD);
      vecs[5]  = mk(0, 3'b101, 32'h12, 32'h0, 32'h0, 5'd8, 0, 2'b00, 32'h0000DEAD);
      vecs[6]  = mk(1, 3'b001, 32'h20, 32'h1, 32'h1234, 5'd0, 1, 2'b10, 32'h0);
      vecs[7]  = mk(0, 3'b010, 32'h1000, 32'h0, 32'h0, 5'd3, 1, 2'b00, 32'h0);
      vecs[8]  = mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 5'd3, 1, 2'b11, 32'h0);
      vecs[9]  = mk(0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd0, 0, 2'b00, 32'hDEADBEEF);
      vecs[10] = mk(0, 3'b010, 32'hFFFFFFF0, 32'h20, 32'h0, 5'd9, 0, 2'b00, 32'hDEADBEEF);
      vecs[11] = mk(1, 3'b000, 32'h3, 32'h10, 32'h55, 5'd0, 0, 2'b00, 32'h0);
      vecs[12] = mk(0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd10, 0, 2'b00, 32'h55ADBEEF);
      vecs[13] = mk(0, 3'b001, 32'h11, 32'h0, 32'h0, 5'd11, 1, 2'b01, 32'h0);
      vecs[14] = mk(1, 3'b111, 32'h1, 32'h0, 32'h0, 5'd0, 1, 2'b11, 32'h0);
      vecs[15] = mk(0, 3'b110, 32'h2000, 32'h0, 32'h0, 5'd1, 1, 2'b11, 32'h0);
      vecs[16] = mk(0, 3'b010, 32'h1002, 32'h0, 32'h0, 5'd1, 1, 2'b01, 32'h0);
      vecs[17] = mk(1, 3'b010, 32'hFF0, 32'hC, 32'h12345678, 5'd0, 0, 2'b00, 32'h0);
      vecs[18] = mk(0, 3'b010, 32'hFFC, 32'h0, 32'h0, 5'd31, 0, 2'b00, 32'h12345678);
      vecs[19] = mk(0, 3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd2, 0, 2'b00, 32'h0);
      vecs[20] = mk(0, 3'b010, 32'hFFFFFFF0, 32'h0, 32'h0, 5'd2, 1, 2'b00, 32'h0);
      vecs[21] = mk(1, 3'b001, 32'h22, 32'h0, 32'h0000A5C3, 5'd0, 0, 2'b00, 32'h0);
      vecs[22] = mk(0, 3'b101, 32'h22, 32'h0, 32'h0, 5'd12, 0, 2'b00, 32'h0000A5C3);
      vecs[23] = mk(0, 3'b000, 32'h22, 32'h0, 32'h0, 5'd13, 0, 2'b00, 32'hFFFFFFC3);

      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = '0;
      bus.req_base = '0; bus.req_offset = '0; bus.req_wdata = '0; bus.req_rd = '0;
      bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_resp_outputs", outv(), 80'h0);
      chk("rst_mem_outputs", memv(), 80'h0);
      chk("rst_req_ready", 80'(bus.req_ready), 80'(1));
      rst = 1'b0;
      bus.resp_ready = 1'b1;

      for (int i = 0; i < 24; i++) begin
         send(vecs[i], 1'b1);
         drain();
      end

      // Backpressure: response must sit unchanged until the single-cycle resp_ready pulse.
      bus.resp_ready = 1'b0;
      hs0 = hs_cnt;
      send(mk(0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd7, 0, 2'b00, 32'h55ADBEEF), 1'b1);
      for (int i = 0; i < 20 && !bus.resp_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", outv(), {6'b0, 1'b1, 32'h55ADBEEF, 5'd7, 1'b1, 1'b0, 2'b00, 32'h0});
      end
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      chk("bp_one_completion", 80'(hs_cnt - hs0), 80'(1));
      chk("bp_valid_dropped", 80'(bus.resp_valid), 80'(0));

      // Reset while the load sits in WAIT: request vanishes without a response.
      hs0 = hs_cnt;
      send(mk(0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd4, 0, 2'b00, 32'h0), 1'b0);
      @(negedge clk);
      chk("rst_test_issue", 80'(mem_read_en), 80'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_resp_outputs", outv(), 80'h0);
      chk("rst_mid_mem_outputs", memv(), 80'h0);
      rst = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_req_ready", 80'(bus.req_ready), 80'(1));
      chk("rst_mid_no_valid", 80'(bus.resp_valid), 80'(0));
      repeat (6) @(negedge clk);
      chk("rst_mid_no_completion", 80'(hs_cnt - hs0), 80'(0));

      send(mk(0, 3'b100, 32'h13, 32'h0, 32'h0, 5'd14, 0, 2'b00, 32'h00000055), 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
